// File: rtl/matrix_memory_responder.sv
// Vector memory for the Transformation_Block read port: weight columns and feature rows,
// filled by an element-serial loader and read back one full vector per cycle.

// One element position across every stored vector, plus that position's output register.
module matrix_memory_responder_lane #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_VEC    = 9,
  parameter int IDX_W      = 7,
  parameter int SEL_W      = 4,
  parameter int LANE_ID    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_load,
  input  logic                  rd_zero,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [NUM_VEC];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VEC; v++) mem[v] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && wr_idx == IDX_W'(LANE_ID)) mem[wr_sel] <= wr_data;
      if (rd_load)      rd_data <= mem[rd_sel];
      else if (rd_zero) rd_data <= '0;
    end
  end
endmodule

module matrix_memory_responder #(
  parameter int DATA_WIDTH    = 5,
  parameter int VECTOR_SIZE   = 96,
  parameter int ADDRESS_WIDTH = 13,
  parameter int WEIGHT_COLS   = 3,
  parameter int FEATURE_ROWS  = 6,
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = 13'h200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_read,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0]    data_out [0:VECTOR_SIZE-1],
  output logic                     read_valid,
  output logic                     addr_error,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [DATA_WIDTH-1:0]    load_data,
  output logic                     load_ready,
  output logic                     load_done,
  output logic                     mem_ready
);
  localparam int NUM_VEC = WEIGHT_COLS + FEATURE_ROWS;
  localparam int IDX_W   = $clog2(VECTOR_SIZE);
  localparam int SEL_W   = $clog2(NUM_VEC);
  localparam int FROW_W  = $clog2(FEATURE_ROWS);

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_F, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [SEL_W-1:0]  vec;
  logic [SEL_W-1:0]  wr_sel, rd_sel;
  logic [FROW_W-1:0] f_row;
  logic              xfer, idx_last, rst_seen;
  logic              w_hit, f_hit, mapped, rd_load, rd_zero;

  assign xfer     = load_valid && load_ready;
  assign idx_last = (idx == IDX_W'(VECTOR_SIZE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE:   if (load_start) state_nxt = LOAD_W;
      LOAD_W: begin
        load_ready = 1'b1;
        if (xfer && idx_last && vec == SEL_W'(WEIGHT_COLS - 1)) state_nxt = LOAD_F;
      end
      LOAD_F: begin
        load_ready = 1'b1;
        if (xfer && idx_last && vec == SEL_W'(FEATURE_ROWS - 1)) state_nxt = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_seen <= 1'b0;
    else        rst_seen <= 1'b1;
  end
  assign mem_ready = (state == IDLE) && rst_seen;

  // Counters restart on entry to each load phase; the final write of a phase
  // still uses the pre-clear (vec, idx) since the write decodes combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      vec <= '0;
    end else if (state_nxt != state && (state_nxt == LOAD_W || state_nxt == LOAD_F)) begin
      idx <= '0;
      vec <= '0;
    end else if (xfer) begin
      idx <= idx_last ? '0 : idx + 1'b1;
      if (idx_last) vec <= vec + 1'b1;
    end
  end

  // Weight columns occupy vector slots 0..WEIGHT_COLS-1, feature rows follow.
  assign wr_sel = (state == LOAD_F) ? SEL_W'(WEIGHT_COLS) + vec : vec;

  assign w_hit   = read_address < ADDRESS_WIDTH'(WEIGHT_COLS);
  assign f_hit   = (read_address >= FEATURE_BASE) &&
                   (read_address < FEATURE_BASE + ADDRESS_WIDTH'(FEATURE_ROWS));
  assign f_row   = FROW_W'(read_address - FEATURE_BASE);
  assign mapped  = w_hit || f_hit;
  assign rd_sel  = w_hit ? SEL_W'(read_address) : SEL_W'(WEIGHT_COLS) + SEL_W'(f_row);
  assign rd_load = enable_read && mem_ready && mapped;
  assign rd_zero = enable_read && mem_ready && !mapped;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_valid <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      read_valid <= enable_read && mem_ready;
      addr_error <= enable_read && !(mem_ready && mapped);
    end
  end

  for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_lane
    matrix_memory_responder_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_VEC    (NUM_VEC),
      .IDX_W      (IDX_W),
      .SEL_W      (SEL_W),
      .LANE_ID    (g)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (xfer),
      .wr_idx  (idx),
      .wr_sel  (wr_sel),
      .wr_data (load_data),
      .rd_load (rd_load),
      .rd_zero (rd_zero),
      .rd_sel  (rd_sel),
      .rd_data (data_out[g])
    );
  end
endmodule

// File: tb/tb_matrix_memory_responder.sv
// Scoreboard bench for matrix_memory_responder: reads push expected responses,
// a negedge monitor pops and compares them one cycle later.
module tb_matrix_memory_responder;
  localparam int DW = 5, VS = 96, AW = 13, NV = 9, TOT = 864;
  localparam int FW = DW * VS;

  logic          clk = 1'b0, reset = 1'b0;
  logic          enable_read = 1'b0, load_start = 1'b0, load_valid = 1'b0;
  logic [AW-1:0] read_address = '0;
  logic [DW-1:0] load_data = '0;
  logic [DW-1:0] data_out [0:VS-1];
  logic          read_valid, addr_error, load_ready, load_done, mem_ready;

  always #5 clk = ~clk;

  matrix_memory_responder dut (
    .clk(clk), .reset(reset), .enable_read(enable_read), .read_address(read_address),
    .data_out(data_out), .read_valid(read_valid), .addr_error(addr_error),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .mem_ready(mem_ready)
  );

  typedef struct { int due; logic rv; logic err; logic [FW-1:0] data; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] model [NV][VS];
  logic [FW-1:0] last_data = '0;
  int            cyc = 0, n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] flat_out();
    logic [FW-1:0] r;
    for (int i = 0; i < VS; i++) r[i*DW +: DW] = data_out[i];
    return r;
  endfunction

  function automatic logic [FW-1:0] pack_vec(input int v);
    logic [FW-1:0] r;
    for (int i = 0; i < VS; i++) r[i*DW +: DW] = model[v][i];
    return r;
  endfunction

  function automatic int decode(input logic [AW-1:0] a);
    if (a < 13'd3) return int'(a);
    if (a >= 13'h200 && a < 13'h206) return 3 + int'(a - 13'h200);
    return -1;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("read_valid", FW'(read_valid), FW'(e.rv));
      chk("addr_error", FW'(addr_error), FW'(e.err));
      chk("data_out", flat_out(), e.data);
    end else if (reset) begin
      chk("idle_valid", FW'(read_valid), '0);
      chk("idle_error", FW'(addr_error), '0);
    end
  end

  // Drive one read at the current negedge; ok=0 means the memory is expected busy.
  task automatic rd(input logic [AW-1:0] a, input bit ok);
    exp_t e;
    int v;
    v = decode(a);
    enable_read = 1'b1;
    read_address = a;
    e.due = cyc + 1;
    if (!ok) begin
      e.rv = 1'b0; e.err = 1'b1; e.data = last_data;
    end else if (v < 0) begin
      e.rv = 1'b1; e.err = 1'b1; e.data = '0;
    end else begin
      e.rv = 1'b1; e.err = 1'b0; e.data = pack_vec(v);
    end
    last_data = e.data;
    sb.push_back(e);
  endtask

  task automatic rd_list(input logic [AW-1:0] list [$]);
    foreach (list[i]) begin
      rd(list[i], 1'b1);
      @(negedge clk);
    end
    enable_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all();
    logic [AW-1:0] l [$];
    l = '{13'h000, 13'h001, 13'h002, 13'h200, 13'h201, 13'h202, 13'h203, 13'h204, 13'h205};
    rd_list(l);
  endtask

  task automatic do_reset();
    enable_read = 1'b0; load_valid = 1'b0; load_start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int v = 0; v < NV; v++) for (int i = 0; i < VS; i++) model[v][i] = '0;
    last_data = '0;
    @(negedge clk);
    chk("mem_ready_after_reset", FW'(mem_ready), FW'(1));
  endtask

  // Full stream load; optional rejected read, ignored restart, or reset abort at element k.
  task automatic do_load(input bit bp, input int rd_at, input int restart_at, input int abort_at);
    int k, c_first, c_last, guard;
    bit early, not_ready;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    k = 0; guard = 0; early = 0; not_ready = 0; c_first = -1; c_last = 0;
    while (k < TOT && guard < 20000) begin
      guard++;
      if (load_done) early = 1;
      enable_read = 1'b0;
      if (k == abort_at) begin
        do_reset();
        return;
      end
      if (k == rd_at) begin
        rd(13'h000, 1'b0);
        rd_at = -1;
      end
      load_start = (k == restart_at);
      load_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data = DW'(k % 32);
      if (load_valid) begin
        if (!load_ready) not_ready = 1;
        if (c_first < 0) c_first = cyc;
        model[k / VS][k % VS] = load_data;
        c_last = cyc;
        k++;
      end
      @(negedge clk);
    end
    load_valid = 1'b0; load_start = 1'b0; enable_read = 1'b0;
    chk("load_timeout", FW'(guard < 20000), FW'(1));
    chk("early_done", FW'(early), '0);
    chk("load_ready_low", FW'(not_ready), '0);
    chk("load_done", FW'(load_done), FW'(1));
    chk("done_latency", FW'(cyc - c_last), FW'(1));
    if (!bp) chk("done_864", FW'(cyc - c_first), FW'(TOT));
    chk("mem_ready_in_done", FW'(mem_ready), '0);
    @(negedge clk);
    chk("done_pulse", FW'(load_done), '0);
    chk("mem_ready_idle", FW'(mem_ready), FW'(1));
  endtask

  initial begin
    logic [AW-1:0] l [$];
    for (int v = 0; v < NV; v++) for (int i = 0; i < VS; i++) model[v][i] = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_read_valid", FW'(read_valid), '0);
    chk("rst_addr_error", FW'(addr_error), '0);
    chk("rst_load_ready", FW'(load_ready), '0);
    chk("rst_load_done", FW'(load_done), '0);
    chk("rst_mem_ready", FW'(mem_ready), '0);
    chk("rst_data", flat_out(), '0);
    reset = 1'b1;
    @(negedge clk);
    chk("mem_ready_release", FW'(mem_ready), FW'(1));
    l = '{13'h000, 13'h205};
    rd_list(l);

    do_load(1'b0, -1, -1, -1);
    l = '{13'h001, 13'h200, 13'h205};
    rd_list(l);
    check_all();
    l = '{13'h003, 13'h1FF, 13'h206, 13'h1FFF};
    rd_list(l);

    do_reset();
    check_all();
    do_load(1'b1, -1, -1, -1);
    check_all();

    do_load(1'b0, 400, 500, -1);
    check_all();

    do_load(1'b0, -1, -1, 400);
    check_all();
    do_load(1'b0, -1, -1, -1);
    check_all();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", FW'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
